// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Round controller for the red-light/green-light game. Sequences
//            intro, instruction, alternating green/red phases, kill and
//            result screens, tracks per-player alive/finished status and
//            issues kill requests to the servo driver (req/ack).
// Ports    : i_clk_25      system clock (25 MHz VGA domain)
//            i_rst         synchronous active-high reset
//            i_next        debounced "next" button level (edge-detected here)
//            i_rand        random phase-length offset, sampled at phase entry
//            i_detect      per-player motion detected
//            i_finish      per-player reached the finish line
//            i_kill_ack    servo driver completion pulse
//            o_state       state encoding (IDLE=0 .. END=6)
//            o_green       high while in GREEN
//            o_alive       alive mask
//            o_finished    finished mask
//            o_kill_req    kill request to servo driver
//            o_kill_idx    player targeted by the kill request
//            o_phase_left  ticks remaining in the current phase
//            o_win         high in RESULT when at least one player finished
// Options  : GAME_CTRL_TIMEOUT_EN - global game-time limit of LIMIT_TICKS.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl #(
  parameter int N_PLAYERS   = 2,
  parameter int TICK_CYCLES = 25000000,
  parameter int RAND_W      = 3,
  parameter int MIN_TICKS   = 2,
  parameter int LIMIT_TICKS = 60
) (
  input  logic                                        i_clk_25,
  input  logic                                        i_rst,
  input  logic                                        i_next,
  input  logic [RAND_W-1:0]                           i_rand,
  input  logic [N_PLAYERS-1:0]                        i_detect,
  input  logic [N_PLAYERS-1:0]                        i_finish,
  input  logic                                        i_kill_ack,
  output logic [2:0]                                  o_state,
  output logic                                        o_green,
  output logic [N_PLAYERS-1:0]                        o_alive,
  output logic [N_PLAYERS-1:0]                        o_finished,
  output logic                                        o_kill_req,
  output logic [((N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1)-1:0] o_kill_idx,
  output logic [7:0]                                  o_phase_left,
  output logic                                        o_win
);

  localparam int IDX_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_TICK_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [7:0]       C_MIN_TICKS = 8'(MIN_TICKS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INST   = 3'd1,
    S_GREEN  = 3'd2,
    S_RED    = 3'd3,
    S_KILL   = 3'd4,
    S_RESULT = 3'd5,
    S_END    = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_next_d;
  logic [CNT_W-1:0]     r_tick_cnt;
  logic [7:0]           r_phase, w_phase_nxt;
  logic [N_PLAYERS-1:0] r_alive, w_alive_nxt;
  logic [N_PLAYERS-1:0] r_fin, w_fin_nxt;
  logic [N_PLAYERS-1:0] r_pend, w_pend_nxt;
  logic [N_PLAYERS-1:0] w_act_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic                 r_req, w_req_nxt;
  logic                 r_green, r_win;

  logic                 w_next_evt;
  logic                 w_tick;
  logic                 w_in_phase;
  logic [N_PLAYERS-1:0] w_active;
  logic [7:0]           w_reload;
  logic                 w_limit;

  assign w_next_evt = i_next & ~r_next_d;
  assign w_tick     = (r_tick_cnt == C_TICK_LAST);
  assign w_in_phase = (r_state == S_GREEN) || (r_state == S_RED);
  assign w_active   = r_alive & ~r_fin;
  assign w_reload   = C_MIN_TICKS + 8'(i_rand);

  function automatic logic [IDX_W-1:0] f_lowest(input logic [N_PLAYERS-1:0] v);
    f_lowest = '0;
    for (int k = N_PLAYERS - 1; k >= 0; k--) begin
      if (v[k]) f_lowest = IDX_W'(k);
    end
  endfunction

`ifdef GAME_CTRL_TIMEOUT_EN
  localparam int TOT_W = $clog2(LIMIT_TICKS + 1);
  logic [TOT_W-1:0] r_total;
  logic             r_limit;

  // Sticky once reached so a KILL in progress can finish before RESULT.
  assign w_limit = r_limit ||
                   (w_in_phase && w_tick && (r_total == TOT_W'(LIMIT_TICKS - 1)));

  always_ff @(posedge i_clk_25) begin
    if (i_rst) begin
      r_total <= '0;
      r_limit <= 1'b0;
    end else if (r_state == S_INST && w_next_evt) begin
      r_total <= '0;
      r_limit <= 1'b0;
    end else begin
      if (w_in_phase && w_tick) r_total <= r_total + 1'b1;
      r_limit <= w_limit;
    end
  end
`else
  assign w_limit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_alive_nxt = r_alive;
    w_fin_nxt   = r_fin;
    w_pend_nxt  = r_pend;
    w_idx_nxt   = r_idx;
    w_req_nxt   = r_req;
    w_act_nxt   = w_active;
    case (r_state)
      S_IDLE: if (w_next_evt) w_state_nxt = S_INST;
      S_INST: begin
        if (w_next_evt) begin
          w_state_nxt = S_GREEN;
          w_alive_nxt = '1;
          w_fin_nxt   = '0;
          w_pend_nxt  = '0;
          w_phase_nxt = w_reload;
        end
      end
      S_GREEN, S_RED: begin
        // Phase count never drops below 1 so a RED resumed after KILL can
        // still expire.
        if (w_tick && r_phase > 8'd1) w_phase_nxt = r_phase - 8'd1;
        if (r_state == S_GREEN) begin
          w_fin_nxt = r_fin | (i_finish & w_active);
        end else begin
          w_pend_nxt = r_pend | (i_detect & w_active);
          w_fin_nxt  = r_fin | (i_finish & w_active & ~i_detect);
        end
        w_act_nxt = r_alive & ~w_fin_nxt;
        if (|w_pend_nxt) begin
          w_state_nxt = S_KILL;
          w_idx_nxt   = f_lowest(w_pend_nxt);
          w_req_nxt   = 1'b1;
        end else if (w_act_nxt == '0 || w_limit) begin
          w_state_nxt = S_RESULT;
          w_alive_nxt = r_alive & w_fin_nxt;
        end else if (w_tick && r_phase == 8'd1) begin
          w_state_nxt = (r_state == S_GREEN) ? S_RED : S_GREEN;
          w_phase_nxt = w_reload;
        end
      end
      S_KILL: begin
        // After an ack with more victims queued, req stays low one cycle
        // before being re-raised for the next target.
        if (!r_req) begin
          w_req_nxt = 1'b1;
        end else if (i_kill_ack) begin
          w_alive_nxt = r_alive & ~(N_PLAYERS'(1) << r_idx);
          w_pend_nxt  = r_pend  & ~(N_PLAYERS'(1) << r_idx);
          w_req_nxt   = 1'b0;
          w_act_nxt   = w_alive_nxt & ~r_fin;
          if (|w_pend_nxt) begin
            w_idx_nxt = f_lowest(w_pend_nxt);
          end else if (w_act_nxt == '0 || w_limit) begin
            w_state_nxt = S_RESULT;
            w_alive_nxt = w_alive_nxt & r_fin;
          end else begin
            w_state_nxt = S_RED;
          end
        end
      end
      S_RESULT: if (w_next_evt) w_state_nxt = S_END;
      S_END:    if (w_next_evt) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_25) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_next_d   <= 1'b0;
      r_tick_cnt <= '0;
      r_phase    <= '0;
      r_alive    <= '0;
      r_fin      <= '0;
      r_pend     <= '0;
      r_idx      <= '0;
      r_req      <= 1'b0;
      r_green    <= 1'b0;
      r_win      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_next_d <= i_next;
      if (w_state_nxt != r_state)  r_tick_cnt <= '0;
      else if (r_state == S_KILL)  r_tick_cnt <= r_tick_cnt;
      else if (w_tick)             r_tick_cnt <= '0;
      else                         r_tick_cnt <= r_tick_cnt + 1'b1;
      r_phase <= w_phase_nxt;
      r_alive <= w_alive_nxt;
      r_fin   <= w_fin_nxt;
      r_pend  <= w_pend_nxt;
      r_idx   <= w_idx_nxt;
      r_req   <= w_req_nxt;
      r_green <= (w_state_nxt == S_GREEN);
      r_win   <= (w_state_nxt == S_RESULT) && (|w_fin_nxt);
    end
  end

  assign o_state      = r_state;
  assign o_green      = r_green;
  assign o_alive      = r_alive;
  assign o_finished   = r_fin;
  assign o_kill_req   = r_req;
  assign o_kill_idx   = r_idx;
  assign o_phase_left = r_phase;
  assign o_win        = r_win;

endmodule
`default_nettype wire
